// File: rtl/uart_pkg.sv
// uart_pkg: shared UART byte width and transmit-message sequencer states
package uart_pkg;
  localparam int UART_BYTE_W = 8;
  typedef enum logic [2:0] {IDLE, CHECK, LOAD, SETTLE, DONE} tx_msg_state_t;
endpackage

// File: rtl/tx_msg_writer.sv
// tx_msg_writer: pushes a latched payload plus optional XOR checksum into the UART TX FIFO
module tx_msg_writer
  import uart_pkg::*;
#(
  parameter int NBYTES   = 5,
  parameter int CHECKSUM = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [UART_BYTE_W*NBYTES-1:0] datain,
  input  logic                          txfull,
  output logic                          ldtxdata,
  output logic [UART_BYTE_W-1:0]        txdata,
  output logic                          busy,
  output logic                          done
);
  localparam int CW = $clog2(NBYTES + 2);
  localparam logic [CW-1:0] NPAY = CW'(NBYTES);
  localparam logic [CW-1:0] LAST = CW'(NBYTES + CHECKSUM);
  tx_msg_state_t state;
  logic [CW-1:0] cnt;
  logic [NBYTES-1:0][UART_BYTE_W-1:0] payload;
  logic [UART_BYTE_W-1:0] csum;
  logic [UART_BYTE_W-1:0] pay_byte;
  logic [UART_BYTE_W-1:0] cur_byte;
  // pick the payload byte addressed by the counter
  always_comb begin
    pay_byte = '0;
    for (int i = 0; i < NBYTES; i++)
      if (cnt == CW'(i)) pay_byte = payload[i];
  end
  assign cur_byte = (cnt < NPAY) ? pay_byte : csum;
  // sequencer with registered FIFO strobe, data and status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ldtxdata <= 1'b0;
      txdata   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      payload  <= '0;
      csum     <= '0;
    end else begin
      ldtxdata <= 1'b0;
      case (state)
        IDLE: if (start) begin
          payload <= datain;
          cnt     <= '0;
          csum    <= '0;
          busy    <= 1'b1;
          state   <= CHECK;
        end
        CHECK: if (!txfull) state <= LOAD;
        LOAD: begin
          ldtxdata <= 1'b1;
          txdata   <= cur_byte;
          if (cnt < NPAY) csum <= csum ^ cur_byte;
          cnt   <= cnt + CW'(1);
          state <= SETTLE;
        end
        SETTLE: if (cnt == LAST) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end else begin
          state <= CHECK;
        end
        DONE: if (!start) begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_msg_writer.sv
// tb_tx_msg_writer: scoreboard bench for tx_msg_writer with and without checksum
module tb_tx_msg_writer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start0 = 1'b0;
  logic txfull = 1'b0;
  logic txfull0 = 1'b0;
  logic [39:0] datain = '0;
  logic ldtxdata, ldtxdata0, busy, busy0, done, done0;
  logic [7:0] txdata, txdata0;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int k_start = 0;
  int ld0_n = 0;
  logic prev_ld = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp0_q[$];
  int ld_times[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tx_msg_writer #(.NBYTES(5), .CHECKSUM(1)) dut (
    .clk(clk), .reset(reset), .start(start), .datain(datain), .txfull(txfull),
    .ldtxdata(ldtxdata), .txdata(txdata), .busy(busy), .done(done));

  tx_msg_writer #(.NBYTES(5), .CHECKSUM(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .datain(datain), .txfull(txfull0),
    .ldtxdata(ldtxdata0), .txdata(txdata0), .busy(busy0), .done(done0));

  // scoreboard for the checksum instance: every load pops one expected byte
  always @(negedge clk) begin
    logic [7:0] e;
    if (ldtxdata) begin
      ld_times.push_back(cyc);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL load_unexpected: txdata=%h with no byte expected", txdata);
      end else begin
        e = exp_q.pop_front();
        if (txdata !== e) begin
          n_err++;
          $display("FAIL load_byte: txdata=%h expected %h", txdata, e);
        end
      end
      n_cmp++;
      if (prev_ld) begin
        n_err++;
        $display("FAIL ld_consecutive: ldtxdata=1 two cycles running, expected 0 after a load");
      end
    end
    prev_ld = ldtxdata;
  end

  // scoreboard for the no-checksum instance
  always @(negedge clk) begin
    logic [7:0] e;
    if (ldtxdata0) begin
      ld0_n++;
      n_cmp++;
      if (exp0_q.size() == 0) begin
        n_err++;
        $display("FAIL cs0_load_unexpected: txdata=%h with no byte expected", txdata0);
      end else begin
        e = exp0_q.pop_front();
        if (txdata0 !== e) begin
          n_err++;
          $display("FAIL cs0_load_byte: txdata=%h expected %h", txdata0, e);
        end
      end
    end
  end

  task automatic send(input logic [39:0] d);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(d[8*i +: 8]);
      x ^= d[8*i +: 8];
    end
    exp_q.push_back(x);
    @(posedge clk); #1;
    datain = d;
    start = 1'b1;
    @(posedge clk); #1;
    k_start = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 200 && dc < 0; i++) begin
      @(negedge clk);
      if (done) dc = cyc;
    end
    if (dc < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: done=0 after 200 cycles, expected 1");
    end
  endtask

  task automatic wait_loads(input int n);
    for (int i = 0; i < 100 && ld_times.size() < n; i++) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({ldtxdata, txdata, busy, done, ldtxdata0, txdata0, busy0, done0} !== 22'b0) begin
      n_err++;
      $display("FAIL reset_values: ld=%b tx=%h busy=%b done=%b, expected all 0", ldtxdata, txdata, busy, done);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    ld_times.delete();
    repeat (10) @(negedge clk);
    #1;
    n_cmp++;
    if (ld_times.size() != 0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL idle_quiet: loads=%0d busy=%b done=%b, expected 0 0 0", ld_times.size(), busy, done);
    end
  endtask

  task automatic test_nominal;
    int dc;
    ld_times.delete();
    send(40'h5544332211);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_accept: busy=%b expected 1", busy);
    end
    wait_done(dc);
    n_cmp++;
    if (ld_times.size() != 6) begin
      n_err++;
      $display("FAIL nominal_count: loads=%0d expected 6", ld_times.size());
    end
    n_cmp++;
    if (ld_times.size() == 0 || ld_times[0] != k_start + 2) begin
      n_err++;
      $display("FAIL first_load_latency: first load not at start edge+2 (start edge %0d)", k_start);
    end
    for (int i = 1; i < ld_times.size(); i++) begin
      n_cmp++;
      if (ld_times[i] - ld_times[i-1] != 3) begin
        n_err++;
        $display("FAIL load_spacing: gap=%0d expected 3", ld_times[i] - ld_times[i-1]);
      end
    end
    n_cmp++;
    if (dc != k_start + 18) begin
      n_err++;
      $display("FAIL done_latency: done at edge %0d expected %0d", dc, k_start + 18);
    end
    n_cmp++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL nominal_end: busy=%b leftover=%0d expected 0 0", busy, exp_q.size());
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL done_clear: done=%b expected 0", done);
    end
  endtask

  task automatic test_backpressure;
    int dc, n;
    ld_times.delete();
    send(40'h5544332211);
    wait_loads(2);
    txfull = 1'b1;
    n = ld_times.size();
    repeat (10) @(negedge clk);
    #1;
    n_cmp++;
    if (ld_times.size() != n) begin
      n_err++;
      $display("FAIL bp_window: loads=%0d while full, expected %0d", ld_times.size(), n);
    end
    txfull = 1'b0;
    wait_done(dc);
    n_cmp++;
    if (ld_times.size() != 6 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL bp_count: loads=%0d leftover=%0d expected 6 0", ld_times.size(), exp_q.size());
    end
    n_cmp++;
    if (ld_times.size() < 3 || ld_times[2] - ld_times[1] != 12) begin
      n_err++;
      $display("FAIL bp_resume_gap: gap between loads 2 and 3 not 12");
    end
    @(negedge clk);
  endtask

  task automatic test_latch_ignore;
    int dc;
    ld_times.delete();
    send(40'hC3A50F967E);
    datain = '1;
    repeat (4) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    wait_done(dc);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (ld_times.size() != 6 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL latch_one_msg: loads=%0d leftover=%0d expected 6 0", ld_times.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    int dc;
    ld_times.delete();
    send(40'h5544332211);
    wait_loads(2);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({ldtxdata, txdata, busy, done} !== 11'b0) begin
      n_err++;
      $display("FAIL reset_async: ld=%b tx=%h busy=%b done=%b, expected all 0", ldtxdata, txdata, busy, done);
    end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    ld_times.delete();
    send(40'h5544332211);
    wait_done(dc);
    n_cmp++;
    if (ld_times.size() != 6 || exp_q.size() != 0 || ld_times[0] != k_start + 2) begin
      n_err++;
      $display("FAIL reset_restart: loads=%0d leftover=%0d expected 6 0 from byte 0", ld_times.size(), exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_checksum_off;
    logic [39:0] d;
    d = 40'h5544332211;
    for (int i = 0; i < 5; i++) exp0_q.push_back(d[8*i +: 8]);
    @(posedge clk); #1;
    datain = d;
    start0 = 1'b1;
    for (int i = 0; i < 200 && done0 !== 1'b1; i++) @(negedge clk);
    n_cmp++;
    if (done0 !== 1'b1) begin
      n_err++;
      $display("FAIL cs0_done: done=%b expected 1", done0);
    end
    n_cmp++;
    if (ld0_n != 5 || exp0_q.size() != 0) begin
      n_err++;
      $display("FAIL cs0_count: loads=%0d leftover=%0d expected 5 0", ld0_n, exp0_q.size());
    end
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if (done0 !== 1'b1) begin
        n_err++;
        $display("FAIL cs0_done_hold: done=%b expected 1 while start high", done0);
      end
    end
    n_cmp++;
    if (ld0_n != 5) begin
      n_err++;
      $display("FAIL cs0_no_restart: loads=%0d expected 5", ld0_n);
    end
    @(posedge clk); #1 start0 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (done0 !== 1'b1) begin
      n_err++;
      $display("FAIL cs0_done_before_sample: done=%b expected 1", done0);
    end
    @(negedge clk);
    n_cmp++;
    if (done0 !== 1'b0) begin
      n_err++;
      $display("FAIL cs0_done_fall: done=%b expected 0", done0);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_latch_ignore();
    test_reset_mid();
    test_checksum_off();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
